mem_port_arbiter: RTL and testbench

//  Shares the single 32-bit memory port between instruction fetch and the load/store path of the multi-cycle core.

---
 rtl/mem_port_arbiter_pkg.sv | 53 +++++
 rtl/mem_port_arbiter_lsu_align.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter and its lane aligner.
// Trap check helper is only referenced when MEM_ARB_MISALIGN_TRAP_EN is defined.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        MA_IDLE,
        MA_REQ,
        MA_WAIT,
        MA_RESP
    } mem_arb_state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } mem_arb_owner_t;

    // Load funct3 encodings
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    // True when a data access is misaligned for its size or uses an unassigned funct3
    function automatic logic mem_arb_access_bad(input logic       we,
                                                input logic [2:0] funct3,
                                                input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (we) begin
            case (funct3)
                FUNCT3_SB: bad = 1'b0;
                FUNCT3_SH: bad = addr_lo[0];
                FUNCT3_SW: bad = |addr_lo;
                default:   bad = 1'b1;
            endcase
        end else begin
            case (funct3)
                FUNCT3_LB, FUNCT3_LBU: bad = 1'b0;
                FUNCT3_LH, FUNCT3_LHU: bad = addr_lo[0];
                FUNCT3_LW:             bad = |addr_lo;
                default:               bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lsu_align.sv
// Combinational lane aligner: store byte enables / data replication and
// load lane selection with sign or zero extension. Unassigned funct3 values
// fall through to full-word behaviour.
module mem_port_arbiter_lsu_align
    import mem_port_arbiter_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: byte enables and replicated write data
    always_comb begin
        be_o    = '1;
        wdata_o = wdata_i;
        if (we_i) begin
            case (funct3_i)
                FUNCT3_SB: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                FUNCT3_SH: begin
                    be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                    wdata_o = {2{wdata_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Load side: pick the addressed lane and extend it
    always_comb begin
        case (addr_lo_i)
            2'd0:    ld_byte = rdata_i[7:0];
            2'd1:    ld_byte = rdata_i[15:8];
            2'd2:    ld_byte = rdata_i[23:16];
            default: ld_byte = rdata_i[31:24];
        endcase
        ld_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            FUNCT3_LB:  rdata_o = {{24{ld_byte[7]}}, ld_byte};
            FUNCT3_LBU: rdata_o = {24'h000000, ld_byte};
            FUNCT3_LH:  rdata_o = {{16{ld_half[15]}}, ld_half};
            FUNCT3_LHU: rdata_o = {16'h0000, ld_half};
            default:    rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one 32-bit memory port between instruction
// fetch and load/store, data having priority, one transaction in flight.
// Optional feature: define MEM_ARB_MISALIGN_TRAP_EN to reject misaligned or
// illegal data accesses in IDLE with d_err instead of issuing them.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned RSP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

    mem_arb_state_t   state_q, state_d;
    mem_arb_owner_t   owner_q, owner_d;
    logic             we_q, we_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [3:0]       al_be;
    logic [31:0]      al_wdata;
    logic [31:0]      al_rdata;

    // Fetches are latched as LW so the aligner passes the word straight through
    mem_port_arbiter_lsu_align u_lsu_align (
        .we_i      (we_q),
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (mem_rdata),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .rdata_o   (al_rdata)
    );

    // State and latched-request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MA_IDLE;
            owner_q  <= OWN_FETCH;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Next-state, grant, memory request and response outputs
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;

        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        if_err    = 1'b0;
        d_gnt     = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        d_err     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;

        case (state_q)
            MA_IDLE: begin
                if (d_req) begin
                    d_gnt    = 1'b1;
                    owner_d  = OWN_DATA;
                    we_d     = d_we;
                    funct3_d = d_funct3;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                    err_d    = 1'b0;
                    rdata_d  = '0;
                    state_d  = MA_REQ;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
                    if (mem_arb_access_bad(d_we, d_funct3, d_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = MA_RESP;
                    end
`endif
                end else if (if_req) begin
                    if_gnt   = 1'b1;
                    owner_d  = OWN_FETCH;
                    we_d     = 1'b0;
                    funct3_d = FUNCT3_LW;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    err_d    = 1'b0;
                    rdata_d  = '0;
                    state_d  = MA_REQ;
                end
            end
            MA_REQ: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_be    = al_be;
                mem_wdata = we_q ? al_wdata : '0;
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = MA_WAIT;
                end
            end
            MA_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = we_q ? '0 : al_rdata;
                    err_d   = 1'b0;
                    state_d = MA_RESP;
                end else if ((RSP_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = MA_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MA_RESP: begin
                if (owner_q == OWN_DATA) begin
                    d_rvalid = 1'b1;
                    d_rdata  = rdata_q;
                    d_err    = err_q;
                end else begin
                    if_rvalid = 1'b1;
                    if_rdata  = rdata_q;
                    if_err    = err_q;
                end
                state_d = MA_IDLE;
            end
            default: state_d = MA_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized transactions against a byte-level memory and access-size model.
module tb_mem_port_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_m [int unsigned];

    mem_port_arbiter #(.RSP_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_funct3   (d_funct3),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Access size in bytes; unassigned encodings behave as a full word
    function automatic int unsigned acc_size(input bit we, input logic [2:0] f3);
        if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    endfunction

    function automatic bit acc_illegal(input bit we, input logic [2:0] f3);
        if (we) return f3 >= 3'd3;
        return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    endfunction

    function automatic bit trap_bad(input bit we, input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_ARB_MISALIGN_TRAP_EN
        return acc_illegal(we, f3) || ((a % acc_size(we, f3)) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] wa);
        if (mem_m.exists(wa)) return mem_m[wa];
        return wa ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input int unsigned sz,
                                             input int unsigned base, input bit sgn);
        logic [31:0] v;
        v = w >> (8 * base);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // One complete transaction from an IDLE cycle back to the next IDLE cycle.
    // gw: memory grant wait cycles; rw: response delay in WAIT (>= TO never responds).
    task automatic run_txn(input bit is_data, input bit we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int unsigned gw, input int unsigned rw,
                           input bit hold_if, input logic [31:0] ifa);
        int unsigned sz, base;
        logic [31:0] waddr, word, exp_rd, exp_wd;
        logic [3:0]  exp_be;
        bit bad, eff_we, tmo, sgn;

        bad    = is_data && trap_bad(we, f3, addr);
        eff_we = is_data && we;
        sz     = is_data ? acc_size(we, f3) : 4;
        sgn    = is_data && !we && (f3 == 3'd0 || f3 == 3'd1);
        base   = ((addr % 4) / sz) * sz;
        waddr  = addr & 32'hFFFF_FFFC;
        for (int unsigned b = 0; b < 4; b++) begin
            exp_be[b]       = (b >= base) && (b < base + sz);
            exp_wd[8*b +: 8] = wd[8*(b % sz) +: 8];
        end
        if (!eff_we) exp_be = 4'hF;

        if (is_data) begin
            d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd;
        end
        if (!is_data || hold_if) begin
            if_req = 1'b1; if_addr = is_data ? ifa : addr;
        end
        #1;
        check_eq("d_gnt", 32'(d_gnt), 32'(is_data));
        check_eq("if_gnt", 32'(if_gnt), 32'(!is_data));
        tick();
        if (is_data) begin
            d_req = 1'b0; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom);
        end else begin
            if_req = 1'b0; if_addr = $urandom;
        end

        if (bad) begin
            mem_rvalid = 1'b0;
            #1;
            check_eq("trap_no_mem_req", 32'(mem_req), 32'd0);
            check_eq("trap_d_rvalid", 32'(d_rvalid), 32'd1);
            check_eq("trap_d_err", 32'(d_err), 32'd1);
            check_eq("trap_d_rdata", d_rdata, 32'd0);
            tick();
            check_eq("trap_rvalid_end", 32'(d_rvalid), 32'd0);
            return;
        end

        for (int unsigned i = 0; i < gw; i++) begin
            mem_gnt = 1'b0; mem_rvalid = 1'($urandom); mem_rdata = $urandom;
            #1;
            check_eq("mem_req_hold", 32'(mem_req), 32'd1);
            if (hold_if) check_eq("if_gnt_blocked", 32'(if_gnt), 32'd0);
            tick();
        end
        mem_gnt = 1'b1; mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        #1;
        check_eq("mem_req", 32'(mem_req), 32'd1);
        check_eq("mem_we", 32'(mem_we), 32'(eff_we));
        check_eq("mem_addr", mem_addr, waddr);
        check_eq("mem_be", 32'(mem_be), 32'(exp_be));
        if (eff_we) check_eq("mem_wdata", mem_wdata, exp_wd);
        word = rd_word(waddr);
        if (eff_we) begin
            for (int unsigned b = 0; b < 4; b++)
                if (exp_be[b]) word[8*b +: 8] = exp_wd[8*b +: 8];
            mem_m[waddr] = word;
        end
        tick();
        mem_gnt = 1'b0;

        tmo = (rw >= TO);
        for (int unsigned k = 0; k < TO; k++) begin
            mem_rvalid = (k == rw);
            mem_rdata  = (k == rw) ? word : $urandom;
            #1;
            check_eq("mem_req_wait", 32'(mem_req), 32'd0);
            check_eq("rvalid_early", 32'({if_rvalid, d_rvalid}), 32'd0);
            if (hold_if) check_eq("if_gnt_blocked", 32'(if_gnt), 32'd0);
            tick();
            if (k == rw) break;
        end

        exp_rd = (tmo || eff_we) ? 32'd0 : exp_load(word, sz, base, sgn);
        mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        #1;
        if (is_data) begin
            check_eq("d_rvalid", 32'(d_rvalid), 32'd1);
            check_eq("d_rdata", d_rdata, exp_rd);
            check_eq("d_err", 32'(d_err), 32'(tmo));
            check_eq("if_rvalid_idle", 32'(if_rvalid), 32'd0);
        end else begin
            check_eq("if_rvalid", 32'(if_rvalid), 32'd1);
            check_eq("if_rdata", if_rdata, exp_rd);
            check_eq("if_err", 32'(if_err), 32'(tmo));
            check_eq("d_rvalid_idle", 32'(d_rvalid), 32'd0);
        end
        tick();
        mem_rvalid = 1'b0;
        #1;
        check_eq("rvalid_one_cycle", 32'({if_rvalid, d_rvalid}), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_mem"}, 32'({mem_req, mem_we, mem_be}), 32'd0);
        check_eq({tag, "_addr"}, mem_addr, 32'd0);
        check_eq({tag, "_wdata"}, mem_wdata, 32'd0);
        check_eq({tag, "_rsp"}, 32'({if_rvalid, if_err, d_rvalid, d_err, if_gnt, d_gnt}), 32'd0);
        check_eq({tag, "_rdata"}, if_rdata | d_rdata, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_funct3 = '0; d_addr = '0; d_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst_n = 1'b1;
        tick();

        // Fetch with zero-wait memory
        mem_m[32'h100] = 32'h1357_9BDF;
        run_txn(1'b0, 1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 1'b0, 32'h0);

        // Simultaneous requests: data first, fetch on the following IDLE
        run_txn(1'b1, 1'b0, 3'd2, 32'h208, 32'h0, 1, 2, 1'b1, 32'h10C);
        run_txn(1'b0, 1'b0, 3'd2, 32'h10C, 32'h0, 0, 1, 1'b0, 32'h0);

        // Load extension
        mem_m[32'h200] = 32'h8001_7F00;
        run_txn(1'b1, 1'b0, 3'd0, 32'h203, 32'h0, 0, 0, 1'b0, 32'h0);
        run_txn(1'b1, 1'b0, 3'd4, 32'h203, 32'h0, 0, 0, 1'b0, 32'h0);
        run_txn(1'b1, 1'b0, 3'd1, 32'h202, 32'h0, 0, 0, 1'b0, 32'h0);
        run_txn(1'b1, 1'b0, 3'd5, 32'h200, 32'h0, 0, 0, 1'b0, 32'h0);

        // Store lanes
        run_txn(1'b1, 1'b1, 3'd0, 32'h201, 32'h0000_00AB, 0, 0, 1'b0, 32'h0);
        run_txn(1'b1, 1'b1, 3'd1, 32'h202, 32'hFFFF_1234, 0, 0, 1'b0, 32'h0);
        run_txn(1'b1, 1'b0, 3'd2, 32'h200, 32'h0, 0, 0, 1'b0, 32'h0);

        // Response timeout, then normal service resumes
        run_txn(1'b1, 1'b0, 3'd2, 32'h204, 32'h0, 0, TO, 1'b0, 32'h0);
        run_txn(1'b0, 1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 1'b0, 32'h0);

        // Misaligned word load (trapped or issued depending on build)
        run_txn(1'b1, 1'b0, 3'd2, 32'h102, 32'h0, 0, 0, 1'b0, 32'h0);

        // Asynchronous reset while the memory request is outstanding
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'd2; d_addr = 32'h204;
        #1;
        check_eq("rst_pre_gnt", 32'(d_gnt), 32'd1);
        tick();
        d_req = 1'b0;
        #1;
        check_eq("rst_pre_mem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_quiet("async_rst");
        tick();
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = $urandom;
        tick();
        check_eq("late_rsp_ignored", 32'({d_rvalid, if_rvalid, mem_req}), 32'd0);
        mem_rvalid = 1'b0;
        tick();

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            bit          isd, wr, hold;
            logic [31:0] a;
            isd  = 1'($urandom);
            wr   = 1'($urandom);
            hold = isd && 1'($urandom);
            a    = 32'h200 + ($urandom % 64);
            run_txn(isd, wr, 3'($urandom), a, $urandom, $urandom % 3, $urandom % 6,
                    hold, 32'h200 + ($urandom % 64));
            if (hold)
                run_txn(1'b0, 1'b0, 3'd2, if_addr, 32'h0, $urandom % 3, $urandom % 6,
                        1'b0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
